// File: rtl/cpu_pkg.sv
// Shared CPU constants and enumerations used by the next-PC sequencer.
package cpu_pkg;

   localparam int unsigned XLEN       = 32;
   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam int unsigned INSN_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BOOT     = 2'd1,
      RUN      = 2'd2,
      WAIT_MEM = 2'd3
   } pcseq_state_t;

   typedef enum logic [1:0] {
      SRC_SEQ    = 2'd0,
      SRC_PEND   = 2'd1,
      SRC_JUMP   = 2'd2,
      SRC_BRANCH = 2'd3
   } redir_src_t;

endpackage

// File: rtl/pc_redirect_mux.sv
// Priority select of the next fetch address (branch > jump > pending > sequential)
// together with the IF/ID and ID/EX flush requests.
import cpu_pkg::*;

module pc_redirect_mux (
   input  logic            branch_i,
   input  logic [XLEN-1:0] branch_target_i,
   input  logic            jump_i,
   input  logic [XLEN-1:0] jump_target_i,
   input  logic            pend_v_i,
   input  logic [XLEN-1:0] pend_pc_i,
   input  logic [XLEN-1:0] pc_cur_i,
   output logic [XLEN-1:0] target_o,
   output redir_src_t      src_o,
   output logic            if_flush_o,
   output logic            id_flush_o
);

   always_comb begin
      target_o   = pc_cur_i + XLEN'(INSN_BYTES);
      src_o      = SRC_SEQ;
      if_flush_o = 1'b0;
      id_flush_o = 1'b0;
      if (branch_i) begin
         target_o   = branch_target_i;
         src_o      = SRC_BRANCH;
         if_flush_o = 1'b1;
         id_flush_o = 1'b1;
      end else if (jump_i) begin
         target_o   = jump_target_i;
         src_o      = SRC_JUMP;
         if_flush_o = 1'b1;
      end else if (pend_v_i) begin
         target_o   = pend_pc_i;
         src_o      = SRC_PEND;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: boot/run FSM, stall merging and deferred jump redirect.
// Optional performance counters are built when PC_SEQ_PERF_EN is defined.
import cpu_pkg::*;

module pc_sequencer (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [XLEN-1:0] pc_cur_i,
   input  logic            imem_ready_i,
   input  logic            hazard_stall_i,
   input  logic            jump_i,
   input  logic [XLEN-1:0] jump_target_i,
   input  logic            branch_i,
   input  logic [XLEN-1:0] branch_target_i,
   output logic [XLEN-1:0] pc_next_o,
   output logic            pc_we_o,
   output logic            if_flush_o,
   output logic            id_flush_o,
   output logic            busy_o
`ifdef PC_SEQ_PERF_EN
   ,
   input  logic            perf_clr_i,
   output logic [31:0]     perf_stall_cnt_o,
   output logic [31:0]     perf_redirect_cnt_o
`endif
);

   pcseq_state_t    state, state_nxt;
   logic            pend_v;
   logic [XLEN-1:0] pend_pc;
   logic            pend_set, pend_clr;
   logic            apply_redir;
   logic            active;

   logic [XLEN-1:0] mux_target;
   redir_src_t      mux_src;
   logic            mux_if_flush, mux_id_flush;

   pc_redirect_mux u_mux (
      .branch_i        (branch_i),
      .branch_target_i (branch_target_i),
      .jump_i          (jump_i),
      .jump_target_i   (jump_target_i),
      .pend_v_i        (pend_v),
      .pend_pc_i       (pend_pc),
      .pc_cur_i        (pc_cur_i),
      .target_o        (mux_target),
      .src_o           (mux_src),
      .if_flush_o      (mux_if_flush),
      .id_flush_o      (mux_id_flush)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         pend_v  <= 1'b0;
         pend_pc <= '0;
      end else begin
         state <= state_nxt;
         if (pend_set) begin
            pend_v  <= 1'b1;
            pend_pc <= jump_target_i;
         end else if (pend_clr) begin
            pend_v  <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      pc_next_o   = RESET_PC;
      pc_we_o     = 1'b0;
      if_flush_o  = 1'b0;
      id_flush_o  = 1'b0;
      pend_set    = 1'b0;
      pend_clr    = 1'b0;
      apply_redir = 1'b0;
      active      = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) state_nxt = BOOT;
         end
         BOOT: begin
            pc_we_o   = 1'b1;
            state_nxt = RUN;
         end
         RUN, WAIT_MEM: begin
            if (!start_i) begin
               // Leaving RUN abandons any deferred jump; restart reboots at RESET_PC.
               pc_next_o = pc_cur_i;
               pend_clr  = 1'b1;
               state_nxt = IDLE;
            end else begin
               active      = 1'b1;
               if_flush_o  = mux_if_flush;
               id_flush_o  = mux_id_flush;
               pc_we_o     = (imem_ready_i & ~hazard_stall_i) | branch_i;
               pc_next_o   = pc_we_o ? mux_target : pc_cur_i;
               apply_redir = pc_we_o & (mux_src != SRC_SEQ);
               if (branch_i)
                  pend_clr = 1'b1;
               else if (jump_i && !pc_we_o)
                  pend_set = 1'b1;
               else if (apply_redir)
                  pend_clr = 1'b1;
               if (state == RUN) begin
                  if (!imem_ready_i && !branch_i) state_nxt = WAIT_MEM;
               end else if (imem_ready_i) begin
                  state_nxt = RUN;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy_o = (state != IDLE);

`ifdef PC_SEQ_PERF_EN
   always_ff @(posedge clk_i) begin
      if (rst_i || perf_clr_i) begin
         perf_stall_cnt_o    <= '0;
         perf_redirect_cnt_o <= '0;
      end else begin
         if (active && !pc_we_o && perf_stall_cnt_o != 32'hFFFF_FFFF)
            perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
         if (apply_redir && perf_redirect_cnt_o != 32'hFFFF_FFFF)
            perf_redirect_cnt_o <= perf_redirect_cnt_o + 32'd1;
      end
   end
`else
   logic unused_active;
   assign unused_active = active;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default build).
`timescale 1ns/1ps
module tb_pc_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_i, start_i, imem_ready_i, hazard_stall_i, jump_i, branch_i;
   logic [31:0] pc_cur_i, jump_target_i, branch_target_i;
   logic [31:0] pc_next_o;
   logic        pc_we_o, if_flush_o, id_flush_o, busy_o;

   int n_checks = 0;
   int n_pass   = 0;

   pc_sequencer dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .start_i         (start_i),
      .pc_cur_i        (pc_cur_i),
      .imem_ready_i    (imem_ready_i),
      .hazard_stall_i  (hazard_stall_i),
      .jump_i          (jump_i),
      .jump_target_i   (jump_target_i),
      .branch_i        (branch_i),
      .branch_target_i (branch_target_i),
      .pc_next_o       (pc_next_o),
      .pc_we_o         (pc_we_o),
      .if_flush_o      (if_flush_o),
      .id_flush_o      (id_flush_o),
      .busy_o          (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i = 1; start_i = 0; imem_ready_i = 1; hazard_stall_i = 0;
      jump_i = 0; branch_i = 0; pc_cur_i = 0; jump_target_i = 0; branch_target_i = 0;
      tick(); tick();
      check("rst_pc_next", pc_next_o, 32'h0);
      check("rst_pc_we", {31'b0, pc_we_o}, 32'h0);
      check("rst_if_flush", {31'b0, if_flush_o}, 32'h0);
      check("rst_id_flush", {31'b0, id_flush_o}, 32'h0);
      check("rst_busy", {31'b0, busy_o}, 32'h0);

      rst_i = 0; start_i = 1; #1;
      check("idle_pc_we", {31'b0, pc_we_o}, 32'h0);
      tick();
      check("boot_pc_we", {31'b0, pc_we_o}, 32'h1);
      check("boot_pc_next", pc_next_o, 32'h0);
      check("boot_busy", {31'b0, busy_o}, 32'h1);

      tick(); pc_cur_i = 32'h0; #1;
      check("run_seq4", pc_next_o, 32'h4);
      check("run_seq4_we", {31'b0, pc_we_o}, 32'h1);
      tick(); pc_cur_i = 32'h4; #1;
      check("run_seq8", pc_next_o, 32'h8);

      tick(); pc_cur_i = 32'h10; hazard_stall_i = 1; #1;
      check("stall_we", {31'b0, pc_we_o}, 32'h0);
      check("stall_hold", pc_next_o, 32'h10);
      tick(); hazard_stall_i = 0; #1;
      check("unstall_next", pc_next_o, 32'h14);
      check("unstall_we", {31'b0, pc_we_o}, 32'h1);

      tick(); pc_cur_i = 32'h14; hazard_stall_i = 1; branch_i = 1; branch_target_i = 32'h80; #1;
      check("br_stall_we", {31'b0, pc_we_o}, 32'h1);
      check("br_stall_next", pc_next_o, 32'h80);
      check("br_if_flush", {31'b0, if_flush_o}, 32'h1);
      check("br_id_flush", {31'b0, id_flush_o}, 32'h1);

      tick(); hazard_stall_i = 0; branch_i = 0; pc_cur_i = 32'h80;
      jump_i = 1; jump_target_i = 32'h40; imem_ready_i = 0; #1;
      check("jmp_blk_if_flush", {31'b0, if_flush_o}, 32'h1);
      check("jmp_blk_id_flush", {31'b0, id_flush_o}, 32'h0);
      check("jmp_blk_we", {31'b0, pc_we_o}, 32'h0);
      check("jmp_blk_hold", pc_next_o, 32'h80);
      tick(); jump_i = 0; #1;
      check("wait1_we", {31'b0, pc_we_o}, 32'h0);
      check("wait1_if_flush", {31'b0, if_flush_o}, 32'h0);
      check("wait1_busy", {31'b0, busy_o}, 32'h1);
      tick(); #1;
      check("wait2_we", {31'b0, pc_we_o}, 32'h0);
      tick(); imem_ready_i = 1; #1;
      check("pend_apply_we", {31'b0, pc_we_o}, 32'h1);
      check("pend_apply_next", pc_next_o, 32'h40);
      tick(); pc_cur_i = 32'h40; #1;
      check("pend_cleared", pc_next_o, 32'h44);

      tick(); branch_i = 1; branch_target_i = 32'h100; jump_i = 1; jump_target_i = 32'h200; #1;
      check("br_jmp_next", pc_next_o, 32'h100);
      check("br_jmp_id_flush", {31'b0, id_flush_o}, 32'h1);
      tick(); branch_i = 0; jump_i = 0; pc_cur_i = 32'h100; #1;
      check("br_jmp_no_pend", pc_next_o, 32'h104);

      tick(); pc_cur_i = 32'hFFFF_FFFC; #1;
      check("seq_wrap", pc_next_o, 32'h0);

      tick(); pc_cur_i = 32'h200; imem_ready_i = 0; jump_i = 1; jump_target_i = 32'h300; #1;
      check("pend2_blk_we", {31'b0, pc_we_o}, 32'h0);
      tick(); jump_i = 0; rst_i = 1; #1;
      tick(); rst_i = 0; imem_ready_i = 1; #1;
      check("rst_mid_busy", {31'b0, busy_o}, 32'h0);
      check("rst_mid_we", {31'b0, pc_we_o}, 32'h0);
      check("rst_mid_next", pc_next_o, 32'h0);
      tick();
      check("reboot_we", {31'b0, pc_we_o}, 32'h1);
      check("reboot_next", pc_next_o, 32'h0);
      tick(); pc_cur_i = 32'h0; #1;
      check("reboot_no_pend", pc_next_o, 32'h4);

      tick(); start_i = 0; #1;
      check("stop_we", {31'b0, pc_we_o}, 32'h0);
      tick();
      check("stop_busy", {31'b0, busy_o}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
